frame_capture5: RTL

//   Serial-to-parallel capture stage directly upstream of the 5-input code classifier.

---
 rtl/frame_capture5.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/frame_capture5.sv
// ---------------------------------------------------------------------------
// frame_capture5 -- serial-to-parallel capture stage feeding the 5-input code
// classifier. A frame is requested with start, then NBITS data bits arrive MSB
// first, one per bit_vld strobe. The completed code is committed to word_out
// (word_out[4]=A ... word_out[0]=E for NBITS=5) with a one-cycle word_vld pulse.
// word_out only ever changes on a commit (or on reset), so the classifier never
// sees partial data.
//
// Optional feature (compile-time macro PARITY_CHECK_EN):
//   defined   -> one extra even-parity bit follows the data bits (state PAR);
//                a parity failure pulses frame_err instead of committing.
//   undefined -> no PAR state, no parity bit; frame_err means timeout only.
//
// Parameters
//   NBITS    data bits per frame (2..16)
//   TIMEOUT  strobe-less cycles tolerated in SHIFT/PAR before the frame dies
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   frame start request, sampled only in IDLE
//   bit_vld    in   serial bit strobe; ser_in valid in the same cycle
//   ser_in     in   serial data, MSB first
//   abort      in   drop the current frame, back to IDLE
//   word_out   out  last committed word
//   word_vld   out  1-cycle pulse in the cycle word_out takes a new value
//   busy       out  high while a frame is being shifted in (SHIFT/PAR)
//   frame_err  out  1-cycle pulse on timeout or parity failure
//   dbg_state  out  current FSM state encoding, for observation only
//
// Handshake: a bit is consumed in every SHIFT/PAR cycle where bit_vld=1 and no
// higher-priority event (reset > abort > timeout) occurs; there is no ready,
// strobes outside SHIFT/PAR are simply dropped. word_vld/frame_err are
// single-cycle pulses with no back-pressure.
// ---------------------------------------------------------------------------
module frame_capture5 #(
  parameter int NBITS   = 5,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_vld,
  input  logic             ser_in,
  input  logic             abort,
  output logic [NBITS-1:0] word_out,
  output logic             word_vld,
  output logic             busy,
  output logic             frame_err,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(NBITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] LAST_CNT  = CW'(NBITS - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PAR    = 2'd2,
    S_COMMIT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd3
  } state_t;
`endif

  state_t           state_q;
  logic [NBITS-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic [TW-1:0]    timer_q;
  logic [NBITS-1:0] word_q;
  logic             word_vld_q;
  logic             frame_err_q;

  // Shift register value after accepting the current ser_in bit.
  logic [NBITS-1:0] shreg_d;
  assign shreg_d = {shreg_q[NBITS-2:0], ser_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      word_q      <= '0;
      word_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      word_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_q <= S_SHIFT;
            shreg_q <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
          end
        end

        S_SHIFT: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (timer_q == TIMER_MAX) begin
            // Timeout outranks a strobe arriving in the same cycle.
            frame_err_q <= 1'b1;
            state_q     <= S_IDLE;
          end else if (bit_vld) begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_q + 1'b1;
            timer_q <= '0;
            if (cnt_q == LAST_CNT) begin
`ifdef PARITY_CHECK_EN
              state_q <= S_PAR;
`else
              // Commit on the same edge as the last bit so word_out and
              // word_vld are visible in the COMMIT cycle (one cycle after
              // the final strobe).
              word_q     <= shreg_d;
              word_vld_q <= 1'b1;
              state_q    <= S_COMMIT;
`endif
            end
          end else begin
            // Stops at TIMER_MAX because the timeout branch above fires first.
            timer_q <= timer_q + 1'b1;
          end
        end

`ifdef PARITY_CHECK_EN
        S_PAR: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (timer_q == TIMER_MAX) begin
            frame_err_q <= 1'b1;
            state_q     <= S_IDLE;
          end else if (bit_vld) begin
            // Even parity over data plus parity bit.
            if ((^{shreg_q, ser_in}) == 1'b0) begin
              word_q     <= shreg_q;
              word_vld_q <= 1'b1;
              state_q    <= S_COMMIT;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_IDLE;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
`endif

        S_COMMIT: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign word_out  = word_q;
  assign word_vld  = word_vld_q;
  assign frame_err = frame_err_q;
  assign dbg_state = state_q;

`ifdef PARITY_CHECK_EN
  assign busy = (state_q == S_SHIFT) || (state_q == S_PAR);
`else
  assign busy = (state_q == S_SHIFT);
`endif

endmodule
